// File: rtl/rs_enc_param.sv
// Systematic Reed-Solomon encoder over GF(2^8), NPAR parity symbols, K message symbols.
// Define RS_ENC_SHORTEN_EN to let s_last end a message early.
module rs_enc_param #(
  parameter int NPAR = 16,
  parameter int K    = 239
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       s_valid,
  output logic       s_ready,
  input  logic [7:0] s_data,
  input  logic       s_last,
  output logic       m_valid,
  input  logic       m_ready,
  output logic [7:0] m_data,
  output logic       m_parity,
  output logic       m_last
);

  function automatic logic [7:0] gf_mul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1D : 8'h00);
    end
    return p;
  endfunction

  function automatic logic [31:0][7:0] gen_poly(input int n);
    logic [32:0][7:0] g;
    logic [31:0][7:0] res;
    logic [7:0]       root;
    g    = '0;
    g[0] = 8'h01;
    root = 8'h01;
    for (int i = 0; i < n; i++) begin
      for (int j = i + 1; j >= 1; j--)
        g[j] = g[j-1] ^ gf_mul(g[j], root);
      g[0] = gf_mul(g[0], root);
      root = gf_mul(root, 8'h02);
    end
    res = g[31:0];
    return res;
  endfunction

  localparam logic [31:0][7:0] GC = gen_poly(NPAR);

  typedef enum logic {MSG, PAR} state_t;

  state_t     state_q;
  logic [7:0] r_q [NPAR];
  logic [7:0] cnt_q;
  logic [5:0] pcnt_q;
  logic       valid_q;
  logic [7:0] data_q;
  logic       par_q;
  logic       last_q;

  logic       slot_free;
  logic       accept;
  logic       msg_end;
  logic [7:0] fb;
  logic [7:0] prod [NPAR];

  assign slot_free = !valid_q || m_ready;
  assign s_ready   = rst && (state_q == MSG) && slot_free;
  assign accept    = s_valid && s_ready;
  assign fb        = s_data ^ r_q[NPAR-1];

`ifdef RS_ENC_SHORTEN_EN
  assign msg_end = (cnt_q == 8'(K-1)) || s_last;
`else
  // s_last is folded in as a no-op so the port stays connected.
  assign msg_end = (cnt_q == 8'(K-1)) | (s_last & 1'b0);
`endif

  // Constant-coefficient products: each reduces to a fixed XOR network.
  for (genvar i = 0; i < NPAR; i++) begin : g_tap
    assign prod[i] = gf_mul(fb, GC[i]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= MSG;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      valid_q <= 1'b0;
      data_q  <= 8'h00;
      par_q   <= 1'b0;
      last_q  <= 1'b0;
      for (int i = 0; i < NPAR; i++) r_q[i] <= 8'h00;
    end else begin
      unique case (state_q)
        MSG: begin
          if (accept) begin
            valid_q <= 1'b1;
            data_q  <= s_data;
            par_q   <= 1'b0;
            last_q  <= 1'b0;
            r_q[0]  <= prod[0];
            for (int i = 1; i < NPAR; i++)
              r_q[i] <= r_q[i-1] ^ prod[i];
            if (msg_end) begin
              cnt_q   <= '0;
              state_q <= PAR;
            end else begin
              cnt_q <= cnt_q + 8'd1;
            end
          end else if (m_ready) begin
            valid_q <= 1'b0;
          end
        end
        PAR: begin
          if (slot_free) begin
            valid_q <= 1'b1;
            data_q  <= r_q[NPAR-1];
            par_q   <= 1'b1;
            last_q  <= (pcnt_q == 6'(NPAR-1));
            r_q[0]  <= 8'h00;
            for (int i = 1; i < NPAR; i++)
              r_q[i] <= r_q[i-1];
            if (pcnt_q == 6'(NPAR-1)) begin
              pcnt_q  <= '0;
              state_q <= MSG;
            end else begin
              pcnt_q <= pcnt_q + 6'd1;
            end
          end
        end
        default: state_q <= MSG;
      endcase
    end
  end

  assign m_valid  = valid_q;
  assign m_data   = data_q;
  assign m_parity = par_q;
  assign m_last   = last_q;

endmodule

// File: doc/rs_enc_param.md
RS_ENC_PARAM -- requirements
Module: rs_enc_param

Interface
REQ-001 Parameter NPAR, default 16, number of parity symbols per codeword; legal range 2..32.
REQ-002 Parameter K, default 239, number of message symbols per codeword; legal range 1..(255-NPAR).
REQ-003 clk  input  1  clock; all state changes on posedge clk.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 s_valid  input  1  input symbol valid.
REQ-006 s_ready  output  1  block accepts s_data this cycle when s_valid and s_ready are both high.
REQ-007 s_data  input  8  message symbol, GF(2^8) element.
REQ-008 s_last  input  1  last message symbol; used only when RS_ENC_SHORTEN_EN is defined.
REQ-009 m_valid  output  1  output symbol valid.
REQ-010 m_ready  input  1  downstream accepts m_data this cycle.
REQ-011 m_data  output  8  codeword symbol: message symbols first, then parity symbols.
REQ-012 m_parity  output  1  high while m_data is a parity symbol.
REQ-013 m_last  output  1  high on the final parity symbol of a codeword.

Function
REQ-014 Field: GF(2^8), primitive polynomial x^8+x^4+x^3+x^2+1 (0x11D), alpha = 0x02.
REQ-015 Generator: g(x) = product over i=0..NPAR-1 of (x + alpha^i), monic; coefficients g_0..g_NPAR-1 are computed at elaboration, with no runtime tables.
REQ-016 Constant multipliers are XOR networks, one per tap, with no clocked multiply.
REQ-017 LFSR r[0..NPAR-1] of 8-bit registers; on each accepted message symbol, f = s_data ^ r[NPAR-1], r[0] <= g_0*f, and r[i] <= r[i-1] ^ g_i*f for i >= 1.
REQ-018 Output register: s_ready = (state==MSG) && (!m_valid || m_ready); m_valid clears when m_ready is high and no new symbol is loaded.
REQ-019 MSG state: an accepted symbol loads m_data <= s_data with m_parity=0 one cycle later (latency 1), and the message counter increments.
REQ-020 Transition MSG->PAR on acceptance of message symbol K, or of the s_last symbol per REQ-030.
REQ-021 PAR state: s_ready=0; whenever the output slot is free (!m_valid || m_ready), load m_data <= r[NPAR-1] with m_parity=1, shift r[i] <= r[i-1], and set r[0] <= 0.
REQ-022 The NPAR-th parity load sets m_last=1; after it is accepted, the state returns to MSG, and the LFSR and counters are zero.
REQ-023 Back-to-back operation: the first symbol of the next codeword may be accepted in the same cycle the last parity symbol is accepted.
REQ-024 m_ready low holds m_data, m_parity and m_last stable and freezes the LFSR and counters.
REQ-025 s_valid low in MSG inserts bubbles; LFSR state is retained indefinitely.

Reset
REQ-026 rst=0 at a clock edge sets state=MSG, r[*]=0, counters=0, m_valid=0, m_data=0x00, m_parity=0, m_last=0.
REQ-027 Reset mid-codeword discards the partial codeword; the first symbol accepted after reset starts a new codeword.
REQ-028 While rst=0, s_ready=0.

Configuration
REQ-029 Macro RS_ENC_SHORTEN_EN selects shortened-codeword support.
REQ-030 With RS_ENC_SHORTEN_EN defined: an accepted symbol with s_last=1 ends the message (length 1..K); message symbol K ends the message regardless of s_last.
REQ-031 Without RS_ENC_SHORTEN_EN: s_last is ignored and every message is exactly K symbols.

Verification
REQ-032 NPAR=2, K=4, message 00,00,00,01 -> m_data 00,00,00,01,03,02; m_parity=1 on the last two symbols; m_last=1 on 0x02.
REQ-033 NPAR=16, K=239, all-zero message -> 239 zero message symbols followed by 16 zero parity symbols; the last parity symbol has m_last=1.
REQ-034 NPAR=2, K=4, same vector as REQ-032 with m_ready toggling randomly -> identical symbol sequence with no loss or duplication; outputs stable while m_ready=0.
REQ-035 rst pulsed low after 2 of 4 symbols, then message 00,00,00,01 -> output after reset is exactly 00,00,00,01,03,02.
REQ-036 RS_ENC_SHORTEN_EN defined, NPAR=2, K=4, message 00,01 with s_last on 0x01 -> 00,01,03,02; the next codeword starts immediately.
REQ-037 Codeword check: for random K=239/NPAR=16 messages, the 255-symbol output evaluated at alpha^0..alpha^15 equals 0 in every case.
